sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
- Shares one sram-like slave port (toward the AXI bridge) between an instruction-side master and a data-side master.
- Masters are the inst/data bridge outputs: req/wr/size/addr/wdata plus addr_ok/data_ok handshake.
- One transaction outstanding at a time. Data side has priority, bounded by a starvation counter that guarantees instruction fetch progress.

Parameters:
- STARVE_MAX, default 4: maximum consecutive data grants while inst_req is pending. The next grant is then forced to inst. Legal range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  inst master request; held until inst_addr_ok
- inst_wr  in  1  inst write flag
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr  in  32  inst address
- inst_wdata  in  32  inst write data
- inst_rdata  out  32  read data to inst master
- inst_addr_ok  out  1  address accepted (pulse)
- inst_data_ok  out  1  transaction complete (pulse)
- data_req, data_wr, data_size, data_addr, data_wdata  in  1/1/2/32/32  data master request, same rules as inst
- data_rdata  out  32  read data to data master
- data_addr_ok  out  1  address accepted (pulse)
- data_data_ok  out  1  transaction complete (pulse)
- s_req  out  1  slave request
- s_wr  out  1  slave write flag
- s_size  out  2  slave size
- s_addr  out  32  slave address
- s_wdata  out  32  slave write data
- s_rdata  in  32  slave read data
- s_addr_ok  in  1  slave address accepted
- s_data_ok  in  1  slave transaction done
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high, port name reset.
- States: IDLE, ADDR, DATA. Owner register: 0=inst, 1=data.
- Reset values: state=IDLE, owner=0, starve_cnt=0. All slave-side command registers (wr, size, addr, wdata) = 0. busy=0, s_req=0, all *_addr_ok/*_data_ok=0.
- IDLE, grant selection:
  - Both requests high: grant data unless starve_cnt==STARVE_MAX, in which case grant inst.
  - Only one request high: grant it.
  - On grant: latch the winner's wr/size/addr/wdata into the slave command registers, set owner, go ADDR.
- starve_cnt update, applied at each grant:
  - Data granted while inst_req high: starve_cnt +1, saturating at STARVE_MAX.
  - Inst granted: starve_cnt cleared.
  - Data granted with inst_req low: starve_cnt cleared.
- ADDR:
  - s_req=1 (registered decode of state). s_wr/s_size/s_addr/s_wdata come from the latched registers, stable for the whole transaction.
  - On s_addr_ok: pulse owner's *_addr_ok combinationally in that same cycle, go DATA.
  - s_data_ok while in ADDR is ignored.
- DATA:
  - s_req=0.
  - On s_data_ok: pulse owner's *_data_ok combinationally, go IDLE.
- Read data: inst_rdata and data_rdata are both driven directly from s_rdata. Each is valid only in the owner's data_ok cycle.
- Latency:
  - A request sampled in IDLE at cycle N gives s_req=1 at N+1.
  - Minimum transaction is 3 cycles (grant, addr, data).
  - One mandatory IDLE bubble between back-to-back transactions.
- Outside the owner's state, *_addr_ok and *_data_ok are 0. The non-owner master never sees a handshake.
- A master dropping req before addr_ok after grant is a protocol violation. The latched copy still completes on the slave.
- size=3 is passed through unchanged; no checking.
- Reset mid-transaction: returns to IDLE immediately. A late s_data_ok from the abandoned transaction arrives in IDLE and is ignored (no master pulse).

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined: adds outputs inst_grant_cnt[31:0], data_grant_cnt[31:0] and stall_cnt[31:0].
  - inst_grant_cnt / data_grant_cnt: grants per master.
  - stall_cnt: cycles with any *_req high while that master is not granted.
  - All three wrap modulo 2^32 and are cleared by reset.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Single inst read:
  - Stimulus: inst_req=1, addr=0xBFC00000. Slave gives addr_ok 1 cycle after s_req and data_ok 2 cycles later with s_rdata=0x3C08BFAF.
  - Expected: s_addr=0xBFC00000, inst_addr_ok then inst_data_ok single pulses, inst_rdata=0x3C08BFAF, data_* handshakes stay 0.
- Simultaneous requests:
  - Stimulus: inst_req and data_req (write, size=2, wdata=0x12345678) both rise in the same cycle.
  - Expected: data is served first with s_wr=1 and s_wdata=0x12345678. Inst is granted after data_data_ok plus one IDLE cycle.
- Starvation:
  - Stimulus: STARVE_MAX=4, data_req and inst_req held high continuously.
  - Expected grant order: D,D,D,D,I,D,D,D,D,I.
- Slave backpressure:
  - Stimulus: s_addr_ok held low 10 cycles, then high.
  - Expected: s_req high for 11 cycles; s_addr stable throughout.
  - Stimulus: s_data_ok asserted while in ADDR.
  - Expected: ignored, no master data_ok pulse.
- Reset mid-operation:
  - Stimulus: assert reset while in DATA, then release; slave then returns s_data_ok.
  - Expected: busy=0 and s_req=0 the cycle after reset. The stray s_data_ok produces no master data_ok pulse.
- Perf counters (ARB_PERF_CNT_EN defined):
  - Stimulus: run the starvation scenario for 10 grants.
  - Expected: data_grant_cnt=8, inst_grant_cnt=2.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// Two-master (inst/data) arbiter onto one sram-like slave port, one transaction at a time.
// Optional perf counters are compiled in with `define ARB_PERF_CNT_EN.
module sram_like_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,

`ifdef ARB_PERF_CNT_EN
    output logic [31:0] inst_grant_cnt,
    output logic [31:0] data_grant_cnt,
    output logic [31:0] stall_cnt,
`endif
    output logic        busy
);

    // Handshake: a master holds req (and its command) until its addr_ok pulse;
    // addr_ok marks the command as taken, data_ok marks completion and rdata valid.
    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state, state_nxt;
    logic        owner, owner_nxt;
    logic [3:0]  starve_cnt, starve_nxt;
    logic        cmd_wr, cmd_wr_nxt;
    logic [1:0]  cmd_size, cmd_size_nxt;
    logic [31:0] cmd_addr, cmd_addr_nxt;
    logic [31:0] cmd_wdata, cmd_wdata_nxt;
    logic        grant_inst, grant_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            starve_cnt <= 4'd0;
            cmd_wr     <= 1'b0;
            cmd_size   <= 2'd0;
            cmd_addr   <= 32'd0;
            cmd_wdata  <= 32'd0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            starve_cnt <= starve_nxt;
            cmd_wr     <= cmd_wr_nxt;
            cmd_size   <= cmd_size_nxt;
            cmd_addr   <= cmd_addr_nxt;
            cmd_wdata  <= cmd_wdata_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        starve_nxt    = starve_cnt;
        cmd_wr_nxt    = cmd_wr;
        cmd_size_nxt  = cmd_size;
        cmd_addr_nxt  = cmd_addr;
        cmd_wdata_nxt = cmd_wdata;
        grant_inst    = 1'b0;
        grant_data    = 1'b0;
        inst_addr_ok  = 1'b0;
        inst_data_ok  = 1'b0;
        data_addr_ok  = 1'b0;
        data_data_ok  = 1'b0;

        case (state)
            IDLE: begin
                // Data wins unless inst has already waited STARVE_MAX data grants.
                if (data_req && !(inst_req && starve_cnt == STARVE_LIM)) begin
                    grant_data = 1'b1;
                end else if (inst_req) begin
                    grant_inst = 1'b1;
                end

                if (grant_data) begin
                    owner_nxt     = 1'b1;
                    cmd_wr_nxt    = data_wr;
                    cmd_size_nxt  = data_size;
                    cmd_addr_nxt  = data_addr;
                    cmd_wdata_nxt = data_wdata;
                    starve_nxt    = !inst_req ? 4'd0 :
                                    (starve_cnt == STARVE_LIM) ? STARVE_LIM : starve_cnt + 4'd1;
                    state_nxt     = ADDR;
                end else if (grant_inst) begin
                    owner_nxt     = 1'b0;
                    cmd_wr_nxt    = inst_wr;
                    cmd_size_nxt  = inst_size;
                    cmd_addr_nxt  = inst_addr;
                    cmd_wdata_nxt = inst_wdata;
                    starve_nxt    = 4'd0;
                    state_nxt     = ADDR;
                end
            end
            ADDR: begin
                if (s_addr_ok) begin
                    data_addr_ok = owner;
                    inst_addr_ok = !owner;
                    state_nxt    = DATA;
                end
            end
            DATA: begin
                if (s_data_ok) begin
                    data_data_ok = owner;
                    inst_data_ok = !owner;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign s_req      = (state == ADDR);
    assign busy       = (state != IDLE);
    assign s_wr       = cmd_wr;
    assign s_size     = cmd_size;
    assign s_addr     = cmd_addr;
    assign s_wdata    = cmd_wdata;
    assign inst_rdata = s_rdata;
    assign data_rdata = s_rdata;

`ifdef ARB_PERF_CNT_EN
    // A requester counts as served in its grant cycle and while it owns the address phase.
    logic inst_served, data_served, stall_evt;
    assign inst_served = grant_inst || (state == ADDR && !owner);
    assign data_served = grant_data || (state == ADDR && owner);
    assign stall_evt   = (inst_req && !inst_served) || (data_req && !data_served);

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_grant_cnt <= 32'd0;
            data_grant_cnt <= 32'd0;
            stall_cnt      <= 32'd0;
        end else begin
            if (grant_inst) inst_grant_cnt <= inst_grant_cnt + 32'd1;
            if (grant_data) data_grant_cnt <= data_grant_cnt + 32'd1;
            if (stall_evt)  stall_cnt      <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: cycle vector table plus hand-written corner sequences.
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 1'b0, inst_wr = 1'b0;
    logic [1:0]  inst_size = 2'd1;
    logic [31:0] inst_addr = 32'hBFC0_0000, inst_wdata = 32'h0000_1111;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req = 1'b0, data_wr = 1'b1;
    logic [1:0]  data_size = 2'd2;
    logic [31:0] data_addr = 32'h8000_1000, data_wdata = 32'h1234_5678;
    logic [31:0] data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata;
    logic [31:0] s_rdata = 32'd0;
    logic        s_addr_ok = 1'b0, s_data_ok = 1'b0;
    logic        busy;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] inst_grant_cnt, data_grant_cnt, stall_cnt;
`endif

    int tests = 0;
    int fails = 0;

    sram_like_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_rdata(s_rdata), .s_addr_ok(s_addr_ok),
        .s_data_ok(s_data_ok),
`ifdef ARB_PERF_CNT_EN
        .inst_grant_cnt(inst_grant_cnt), .data_grant_cnt(data_grant_cnt),
        .stall_cnt(stall_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        inst_req = 1'b0; data_req = 1'b0;
        s_addr_ok = 1'b0; s_data_ok = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic        ireq, dreq, saok, sdok;
        logic [31:0] rdata;
        logic        e_sreq, e_busy, e_iaok, e_idok, e_daok, e_ddok;
        logic        chk_cmd, e_wr;
        logic [1:0]  e_size;
        logic [31:0] e_addr, e_wdata;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] in_bits, input logic [31:0] rd,
                                input logic [5:0] exp_bits, input logic chk, input logic wr,
                                input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        vec_t v;
        {v.ireq, v.dreq, v.saok, v.sdok} = in_bits;
        v.rdata = rd;
        {v.e_sreq, v.e_busy, v.e_iaok, v.e_idok, v.e_daok, v.e_ddok} = exp_bits;
        v.chk_cmd = chk; v.e_wr = wr; v.e_size = sz; v.e_addr = a; v.e_wdata = wd;
        return v;
    endfunction

    vec_t vecs[13];
    logic exp_order[10];
    logic got_order[10];

    initial begin
        localparam logic [31:0] IA = 32'hBFC0_0000, IW = 32'h0000_1111;
        localparam logic [31:0] DA = 32'h8000_1000, DW = 32'h1234_5678;
        int n, cyc, sreq_cycles, stray;
        logic [31:0] addr0;

        // inputs {ireq,dreq,saok,sdok}; expected {s_req,busy,iaok,idok,daok,ddok}
        vecs[0]  = mk(4'b1000, 32'd0,         6'b000000, 0, 0, 2'd0, 0,  0);
        vecs[1]  = mk(4'b1001, 32'd0,         6'b110000, 1, 0, 2'd1, IA, IW);
        vecs[2]  = mk(4'b1010, 32'd0,         6'b111000, 1, 0, 2'd1, IA, IW);
        vecs[3]  = mk(4'b0000, 32'd0,         6'b010000, 1, 0, 2'd1, IA, IW);
        vecs[4]  = mk(4'b0001, 32'h3C08_BFAF, 6'b010100, 1, 0, 2'd1, IA, IW);
        vecs[5]  = mk(4'b0000, 32'd0,         6'b000000, 0, 0, 2'd0, 0,  0);
        vecs[6]  = mk(4'b1100, 32'd0,         6'b000000, 0, 0, 2'd0, 0,  0);
        vecs[7]  = mk(4'b1110, 32'd0,         6'b110010, 1, 1, 2'd2, DA, DW);
        vecs[8]  = mk(4'b1001, 32'hCAFE_F00D, 6'b010001, 1, 1, 2'd2, DA, DW);
        vecs[9]  = mk(4'b1000, 32'd0,         6'b000000, 0, 0, 2'd0, 0,  0);
        vecs[10] = mk(4'b1010, 32'd0,         6'b111000, 1, 0, 2'd1, IA, IW);
        vecs[11] = mk(4'b0001, 32'h0123_4567, 6'b010100, 1, 0, 2'd1, IA, IW);
        vecs[12] = mk(4'b0000, 32'd0,         6'b000000, 0, 0, 2'd0, 0,  0);
        exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        // Reset state, with slave handshakes driven high to show they are ignored in IDLE.
        @(negedge clk);
        s_addr_ok = 1'b1; s_data_ok = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_s_req", {31'd0, s_req}, 0);
        check("rst_cmd", {s_wr, s_size, s_addr[28:0]} | s_wdata, 0);
        check("rst_oks", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
        apply_reset();

        // Cycle table: inst read, then simultaneous data write/inst read.
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            inst_req = vecs[k].ireq; data_req = vecs[k].dreq;
            s_addr_ok = vecs[k].saok; s_data_ok = vecs[k].sdok; s_rdata = vecs[k].rdata;
            #1;
            check($sformatf("vec%0d_s_req", k), {31'd0, s_req}, {31'd0, vecs[k].e_sreq});
            check($sformatf("vec%0d_busy", k), {31'd0, busy}, {31'd0, vecs[k].e_busy});
            check($sformatf("vec%0d_oks", k),
                  {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok},
                  {28'd0, vecs[k].e_iaok, vecs[k].e_idok, vecs[k].e_daok, vecs[k].e_ddok});
            if (vecs[k].chk_cmd) begin
                check($sformatf("vec%0d_s_addr", k), s_addr, vecs[k].e_addr);
                check($sformatf("vec%0d_s_wdata", k), s_wdata, vecs[k].e_wdata);
                check($sformatf("vec%0d_s_wr_size", k), {29'd0, s_wr, s_size},
                      {29'd0, vecs[k].e_wr, vecs[k].e_size});
            end
            if (vecs[k].e_idok) check($sformatf("vec%0d_inst_rdata", k), inst_rdata, vecs[k].rdata);
            if (vecs[k].e_ddok) check($sformatf("vec%0d_data_rdata", k), data_rdata, vecs[k].rdata);
        end

        // Starvation: both masters request continuously, slave always ready.
        apply_reset();
        @(negedge clk);
        inst_req = 1'b1; data_req = 1'b1; s_addr_ok = 1'b1; s_data_ok = 1'b1;
        n = 0;
        for (cyc = 0; cyc < 60 && n < 10; cyc++) begin
            #1;
            if (inst_addr_ok || data_addr_ok) begin
                got_order[n] = data_addr_ok;
                n++;
            end
            if (n < 10) @(negedge clk);
        end
        check("starve_grants", n, 10);
        for (int k = 0; k < n; k++)
            check($sformatf("starve_grant%0d_is_data", k), {31'd0, got_order[k]}, {31'd0, exp_order[k]});
`ifdef ARB_PERF_CNT_EN
        check("perf_data_grants", data_grant_cnt, 8);
        check("perf_inst_grants", inst_grant_cnt, 2);
`endif

        // Backpressure: addr_ok withheld 10 ADDR cycles, stray data_ok while in ADDR.
        apply_reset();
        @(negedge clk);
        inst_req = 1'b1;
        sreq_cycles = 0; stray = 0; addr0 = 32'd0;
        for (cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            s_addr_ok = (sreq_cycles >= 10);
            s_data_ok = (sreq_cycles == 3);
            #1;
            if (s_req) begin
                if (sreq_cycles == 0) addr0 = s_addr;
                else if (s_addr !== addr0) stray++;
                sreq_cycles++;
            end
            if (inst_data_ok || data_data_ok) stray++;
            if (inst_addr_ok) break;
        end
        check("bp_s_req_cycles", sreq_cycles, 11);
        check("bp_addr_value", addr0, 32'hBFC0_0000);
        check("bp_addr_unstable_or_stray_ok", stray, 0);
        @(negedge clk);
        inst_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'h5A5A_0001;
        #1;
        check("bp_data_ok", {31'd0, inst_data_ok}, 1);
        check("bp_inst_rdata", inst_rdata, 32'h5A5A_0001);

        // Reset while in DATA, then a late data_ok from the abandoned transaction.
        @(negedge clk);
        s_data_ok = 1'b0; inst_req = 1'b1;
        @(negedge clk);
        s_addr_ok = 1'b1;
        @(negedge clk);
        inst_req = 1'b0; s_addr_ok = 1'b0;
        #1;
        check("mid_in_data", {30'd0, busy, s_req}, {30'd0, 1'b1, 1'b0});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_after_reset", {30'd0, busy, s_req}, 0);
        @(negedge clk);
        s_data_ok = 1'b1;
        #1;
        check("mid_stray_data_ok", {29'd0, inst_data_ok, data_data_ok, busy}, 0);
        @(negedge clk);
        s_data_ok = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
